// File: rtl/write_buffer_ctrl_if.sv
// write_buffer_ctrl_if: producer/read-side/RAM-write bundle for write_buffer_ctrl; almost_full exists only under ALMOST_FULL_EN
interface write_buffer_ctrl_if #(parameter int n = 3, parameter int w = 8);
  logic         write;
  logic [w-1:0] write_data;
  logic         read_done;
  logic         clr_ovf;
  logic         mem_we;
  logic [n-1:0] mem_waddr;
  logic [w-1:0] mem_wdata;
  logic [n-1:0] write_addr;
  logic [n:0]   count;
  logic         fifo_full;
  logic         fifo_empty;
  logic         overflow;
`ifdef ALMOST_FULL_EN
  logic         almost_full;
  modport master (output write, write_data, read_done, clr_ovf,
                  input mem_we, mem_waddr, mem_wdata, write_addr, count, fifo_full, fifo_empty, overflow, almost_full);
  modport slave  (input write, write_data, read_done, clr_ovf,
                  output mem_we, mem_waddr, mem_wdata, write_addr, count, fifo_full, fifo_empty, overflow, almost_full);
`else
  modport master (output write, write_data, read_done, clr_ovf,
                  input mem_we, mem_waddr, mem_wdata, write_addr, count, fifo_full, fifo_empty, overflow);
  modport slave  (input write, write_data, read_done, clr_ovf,
                  output mem_we, mem_waddr, mem_wdata, write_addr, count, fifo_full, fifo_empty, overflow);
`endif
endinterface

// File: rtl/write_buffer_ctrl.sv
// write_buffer_ctrl: FIFO write-side controller (RAM write port, occupancy, full/empty/overflow); optional almost_full via ALMOST_FULL_EN
module write_buffer_ctrl #(
  parameter int n = 3,
  parameter int w = 8
`ifdef ALMOST_FULL_EN
  , parameter int AF_THRESH = 6
`endif
) (
  input logic clk,
  input logic rst,
  write_buffer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL} state_t;
  localparam logic [n:0] DEPTH = (n+1)'(2**n);
  localparam logic [n:0] DEPTH_M1 = DEPTH - 1'b1;
  localparam logic [n:0] ONE = (n+1)'(1);
  state_t       state_q, state_d;
  logic         wr_acc, rd_acc, full, empty;
  logic         mem_we_q, mem_we_d, ovf_q, ovf_d;
  logic [n-1:0] mem_waddr_q, mem_waddr_d, waddr_q, waddr_d;
  logic [w-1:0] mem_wdata_q, mem_wdata_d;
  logic [n:0]   count_q, count_d;
  assign full   = state_q == S_FULL;
  assign empty  = state_q == S_EMPTY;
  assign wr_acc = bus.write & ~full;
  assign rd_acc = bus.read_done & ~empty;
  // next-state: FSM, RAM strobe capture, pointer, occupancy, sticky overflow
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY:  state_d = wr_acc ? S_ACTIVE : S_EMPTY;
      S_ACTIVE: state_d = (wr_acc & ~rd_acc & count_q == DEPTH_M1) ? S_FULL :
                          (rd_acc & ~wr_acc & count_q == ONE) ? S_EMPTY : S_ACTIVE;
      S_FULL:   state_d = rd_acc ? S_ACTIVE : S_FULL;
      default:  state_d = S_EMPTY;
    endcase
    mem_we_d    = wr_acc;
    mem_waddr_d = wr_acc ? waddr_q : mem_waddr_q;
    mem_wdata_d = wr_acc ? bus.write_data : mem_wdata_q;
    waddr_d     = wr_acc ? waddr_q + 1'b1 : waddr_q;
    count_d     = count_q + (n+1)'(wr_acc) - (n+1)'(rd_acc);
    ovf_d       = (bus.write & full) | (ovf_q & ~bus.clr_ovf);
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      waddr_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      waddr_q     <= waddr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end
`ifdef ALMOST_FULL_EN
  localparam logic [n:0] AF = (n+1)'(AF_THRESH);
  logic af_q;
  // almost_full tracks the occupancy being loaded into count this edge
  always_ff @(posedge clk) begin
    if (rst) af_q <= 1'b0;
    else     af_q <= count_d >= AF;
  end
  assign bus.almost_full = af_q;
`endif
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_waddr  = mem_waddr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.write_addr = waddr_q;
  assign bus.count      = count_q;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_write_buffer_ctrl.sv
// tb_write_buffer_ctrl: directed and randomized checks of write_buffer_ctrl against a queue-based occupancy model
module tb_write_buffer_ctrl;
  localparam int N = 3;
  localparam int W = 8;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] q[$];
  int           m_wptr = 0;
  logic         m_ovf = 1'b0;
  logic         m_we = 1'b0;
  int           m_waddr = 0;
  logic [W-1:0] m_wdata = '0;
  write_buffer_ctrl_if #(.n(N), .w(W)) bus();
  write_buffer_ctrl #(.n(N), .w(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cycle(input logic wr, input logic [W-1:0] d, input logic rd, input logic clr, input logic r);
    logic full, empty, wa, ra;
    bus.write = wr;
    bus.write_data = d;
    bus.read_done = rd;
    bus.clr_ovf = clr;
    rst = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_wptr = 0;
      m_ovf = 1'b0;
      m_we = 1'b0;
      m_waddr = 0;
      m_wdata = '0;
    end else begin
      full = q.size() == DEPTH;
      empty = q.size() == 0;
      wa = wr && !full;
      ra = rd && !empty;
      if (ra) void'(q.pop_front());
      m_we = wa;
      if (wa) begin
        q.push_back(d);
        m_waddr = m_wptr;
        m_wdata = d;
        m_wptr = (m_wptr + 1) % DEPTH;
      end
      m_ovf = (wr && full) || (m_ovf && !clr);
    end
    #1;
    bus.write = 1'b0;
    bus.read_done = 1'b0;
    bus.clr_ovf = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    checks += 8;
    if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.fifo_empty); end
    if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.fifo_full); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.mem_we); end
    if (bus.write_addr !== 3'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", bus.write_addr); end
    if (bus.mem_waddr !== 3'd0) begin errors++; $display("FAIL reset_mem_waddr got=%0d exp=0", bus.mem_waddr); end
    if (bus.mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=00", bus.mem_wdata); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
  endtask
  task automatic test_fill;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      checks += 3;
      if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL fill_we[%0d] got=%b exp=1", i, bus.mem_we); end
      if (bus.mem_waddr !== 3'(i)) begin errors++; $display("FAIL fill_addr[%0d] got=%0d exp=%0d", i, bus.mem_waddr, i); end
      if (bus.mem_wdata !== 8'(8'h10 + i)) begin errors++; $display("FAIL fill_data[%0d] got=%h exp=%h", i, bus.mem_wdata, 8'(8'h10 + i)); end
    end
    checks += 3;
    if (bus.count !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d exp=8", bus.count); end
    if (bus.fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", bus.fifo_full); end
    if (bus.write_addr !== 3'd0) begin errors++; $display("FAIL fill_wrap got=%0d exp=0", bus.write_addr); end
  endtask
  task automatic test_overflow;
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    checks += 3;
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL ovf_we got=%b exp=0", bus.mem_we); end
    if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", bus.count); end
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
    cycle(1'b1, 8'hAB, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", bus.overflow); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
  endtask
  task automatic test_full_wr_rd;
    cycle(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
    checks += 5;
    if (bus.count !== 4'd7) begin errors++; $display("FAIL fullrw_count got=%0d exp=7", bus.count); end
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fullrw_ovf got=%b exp=1", bus.overflow); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL fullrw_we got=%b exp=0", bus.mem_we); end
    if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL fullrw_full got=%b exp=0", bus.fifo_full); end
    if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL fullrw_empty got=%b exp=0", bus.fifo_empty); end
  endtask
  task automatic test_empty_wr_rd;
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", bus.fifo_empty); end
    if (bus.count !== 4'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
    cycle(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
    checks += 5;
    if (bus.count !== 4'd1) begin errors++; $display("FAIL emptyrw_count got=%0d exp=1", bus.count); end
    if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL emptyrw_empty got=%b exp=0", bus.fifo_empty); end
    if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL emptyrw_we got=%b exp=1", bus.mem_we); end
    if (bus.mem_waddr !== 3'd0) begin errors++; $display("FAIL emptyrw_addr got=%0d exp=0", bus.mem_waddr); end
    if (bus.mem_wdata !== 8'h5C) begin errors++; $display("FAIL emptyrw_data got=%h exp=5c", bus.mem_wdata); end
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    checks += 4;
    if (bus.count !== 4'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", bus.count); end
    if (bus.write_addr !== 3'd0) begin errors++; $display("FAIL rstmid_waddr got=%0d exp=0", bus.write_addr); end
    if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%b exp=1", bus.fifo_empty); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we got=%b exp=0", bus.mem_we); end
  endtask
  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 40) % 2 == 0) ? 80 : 30;
      cycle($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < 50, $urandom_range(99) < 10, $urandom_range(99) < 2);
      checks += 8;
      if (bus.count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, bus.count, q.size()); end
      if (bus.fifo_full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full[%0d] got=%b exp=%b", i, bus.fifo_full, q.size() == DEPTH); end
      if (bus.fifo_empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty[%0d] got=%b exp=%b", i, bus.fifo_empty, q.size() == 0); end
      if (bus.write_addr !== 3'(m_wptr)) begin errors++; $display("FAIL rnd_waddr[%0d] got=%0d exp=%0d", i, bus.write_addr, m_wptr); end
      if (bus.mem_we !== m_we) begin errors++; $display("FAIL rnd_we[%0d] got=%b exp=%b", i, bus.mem_we, m_we); end
      if (bus.mem_waddr !== 3'(m_waddr)) begin errors++; $display("FAIL rnd_maddr[%0d] got=%0d exp=%0d", i, bus.mem_waddr, m_waddr); end
      if (bus.mem_wdata !== m_wdata) begin errors++; $display("FAIL rnd_mdata[%0d] got=%h exp=%h", i, bus.mem_wdata, m_wdata); end
      if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", i, bus.overflow, m_ovf); end
`ifdef ALMOST_FULL_EN
      checks++;
      if (bus.almost_full !== (q.size() >= 6)) begin errors++; $display("FAIL rnd_af[%0d] got=%b exp=%b", i, bus.almost_full, q.size() >= 6); end
`endif
    end
  endtask
`ifdef ALMOST_FULL_EN
  task automatic test_almost_full;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL af_at5 got=%b exp=0", bus.almost_full); end
    cycle(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL af_at6 got=%b exp=1", bus.almost_full); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL af_back5 got=%b exp=0", bus.almost_full); end
  endtask
`endif
  initial begin
    bus.write = 1'b0;
    bus.write_data = '0;
    bus.read_done = 1'b0;
    bus.clr_ovf = 1'b0;
    test_reset;
    test_fill;
    test_overflow;
    test_full_wr_rd;
    test_empty_wr_rd;
    test_reset_mid;
`ifdef ALMOST_FULL_EN
    test_almost_full;
`endif
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
